seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexed scan controller for the 4-digit, active-low-anode seven-segment display.
- Sits directly upstream of the 2-to-4 anode decoder. It produces the 2-bit digit index that the decoder turns into one-hot-low anode enables.
- It also presents the hex nibble, decimal point and blank flag for the active digit to the segment encoder.
- The displayed 16-bit value is double-buffered so an update never tears mid-frame.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is held (1 kHz/digit at 100 MHz); legal range >= 2.
- CNT_W, $clog2(REFRESH_DIV), prescaler counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- UpdValid  input  1  one-cycle strobe; UpdData/UpdDp are captured into the pending buffer.
- UpdData  input  16  new display value; [15:12] = leftmost digit.
- UpdDp  input  4  decimal points; bit 3 = leftmost digit.
- BlankLeadZero  input  1  when 1, suppress leading zero digits.
- Enable  input  1  when 0, every digit is blanked and scanning continues.
- DigitSel  output  2  active digit index to the anode decoder; 0 = leftmost (anode pattern 0111), 3 = rightmost (1110).
- Nibble  output  4  hex value of the active digit.
- Dp  output  1  decimal point of the active digit; active-high.
- DigitBlank  output  1  1 = the active digit's segments must be driven off.
- FrameTick  output  1  one-cycle pulse when DigitSel wraps 3->0.
- UpdPending  output  1  1 = the pending buffer holds a value not yet displayed.

Behaviour:
- Reset is synchronous: sampled on the rising clk edge with reset_n=0, and overrides all other inputs that cycle. It applies equally mid-frame.
- Reset values:
  - prescaler = 0
  - DigitSel = 0
  - shadow value = 0, shadow Dp = 0
  - pending buffer = 0, UpdPending = 0
  - Nibble = 0, Dp = 0, DigitBlank = 0, FrameTick = 0
- Prescaler counts 0..REFRESH_DIV-1. In the cycle it equals REFRESH_DIV-1 it wraps to 0 and DigitSel advances (3 wraps to 0). Each DigitSel value is held exactly REFRESH_DIV cycles. A frame is 4*REFRESH_DIV cycles.
- Nibble, Dp, DigitBlank and FrameTick are registered. They change on the same edge as DigitSel and are always consistent with it, with no skew cycle.
- FrameTick = 1 for exactly the first cycle of DigitSel=0 after a wrap. It is not asserted after reset.
- Update capture:
  - UpdValid=1 writes UpdData/UpdDp to the pending buffer and sets UpdPending next cycle.
  - This is always accepted; there is no back-pressure.
  - Multiple strobes within one frame: last one wins.
- Swap:
  - On the advance edge 3->0, if UpdPending=1, shadow <= pending and UpdPending clears.
  - Digit 0 of the new frame is already driven from the new shadow value.
  - If UpdPending=0, the shadow is unchanged.
- UpdValid on the swap edge:
  - The swap uses the pending contents from before this edge.
  - The new data is written to pending, and UpdPending ends up 1.
  - The new data is displayed from the next frame onward.
- Nibble = shadow[15-4*DigitSel -: 4]. Dp = shadowDp[3-DigitSel].
- DigitBlank:
  - 1 if Enable=0.
  - Otherwise 1 if BlankLeadZero=1, DigitSel<3, and the nibble at DigitSel and all nibbles to its left are zero.
  - Otherwise 0.
  - Digit 3 is never zero-blanked, so the value 0 shows "0".
- Enable and BlankLeadZero are sampled on the digit-advance edge only. A change takes effect at the next digit.
- No other state machine. DigitSel is a free-running mod-4 counter gated by the prescaler.

Test Plan:
- Reset timing (REFRESH_DIV=4):
  - Stimulus: reset_n=0 for 2 cycles, then release.
  - Required: all outputs 0.
  - Required: DigitSel sequence 0,1,2,3,0 with each value held 4 cycles.
  - Required: FrameTick high only on cycle 16 after release.
- Frame-boundary update:
  - Stimulus: UpdValid with UpdData=16'h1234 and UpdDp=4'b0100 while DigitSel=1.
  - Required: UpdPending=1 next cycle; digits 1..3 still show 0.
  - Required: at the 3->0 wrap, Nibble=1,2,3,4 for digits 0..3, Dp=1 only on digit 1, and UpdPending=0.
- Leading-zero blanking:
  - Stimulus: shadow=16'h0042, BlankLeadZero=1.
  - Required: DigitBlank=1,1,0,0 for digits 0..3.
  - Stimulus: shadow=16'h0000.
  - Required: DigitBlank=1,1,1,0 and Nibble=0 on digit 3.
- Simultaneous update at swap:
  - Stimulus: pending=16'hAAAA with UpdPending=1, then UpdValid with 16'hBBBB on the 3->0 edge.
  - Required: frame shows AAAA and UpdPending stays 1.
  - Required: the following frame shows BBBB.
- Enable low:
  - Stimulus: Enable=0 over a full frame.
  - Required: DigitBlank=1 on every digit; DigitSel and FrameTick keep scanning.
  - Stimulus: Enable=1 again.
  - Required: unblanking starts at the next digit advance.
- Reset mid-scan:
  - Stimulus: reset_n=0 for 1 cycle at DigitSel=2, prescaler=1, UpdPending=1.
  - Required: next cycle DigitSel=0, prescaler=0, UpdPending=0, shadow=0.
  - Required: a full 4-cycle hold on digit 0 follows.

Source files
------------

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - time-multiplexed 4-digit seven-segment scan controller
//
// Drives the 2-bit digit index for the 2-to-4 anode decoder plus the nibble,
// decimal point and blank flag for the active digit. The display value is
// double-buffered: updates land in a pending buffer and are copied into the
// shadow (displayed) buffer only at the frame boundary, so a frame never tears.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   UpdValid      one-cycle strobe capturing UpdData/UpdDp into the pending buffer
//   UpdData[15:0] new display value, [15:12] = leftmost digit
//   UpdDp[3:0]    decimal points, bit 3 = leftmost digit
//   BlankLeadZero suppress leading zero digits (digit 3 always shown)
//   Enable        0 blanks every digit while scanning continues
//   DigitSel[1:0] active digit index, 0 = leftmost
//   Nibble[3:0]   hex value of the active digit
//   Dp            decimal point of the active digit, active-high
//   DigitBlank    1 = drive the active digit's segments off
//   FrameTick     one-cycle pulse on the first cycle of digit 0 after a wrap
//   UpdPending    pending buffer holds a value not yet displayed

module seg_scan_controller #(
  parameter  int REFRESH_DIV = 100000,
  localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        UpdValid,
  input  logic [15:0] UpdData,
  input  logic [3:0]  UpdDp,
  input  logic        BlankLeadZero,
  input  logic        Enable,
  output logic [1:0]  DigitSel,
  output logic [3:0]  Nibble,
  output logic        Dp,
  output logic        DigitBlank,
  output logic        FrameTick,
  output logic        UpdPending
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] prescaler;
  logic [15:0]      pend_val;
  logic [3:0]       pend_dp;
  logic [15:0]      shadow_val;
  logic [3:0]       shadow_dp;

  logic             advance;
  logic             wrap;
  logic             swap;
  logic [1:0]       sel_nxt;
  logic [15:0]      shadow_val_nxt;
  logic [3:0]       shadow_dp_nxt;
  logic [3:0]       nib_nxt;
  logic             dp_nxt;
  logic             blank_nxt;
  logic             lz0, lz1, lz2;

  assign advance = (prescaler == PRE_LAST);
  assign wrap    = advance && (DigitSel == 2'd3);
  assign swap    = wrap && UpdPending;
  assign sel_nxt = DigitSel + 2'd1;

  // The output registers load on the advance edge from the post-swap shadow,
  // so digit 0 of a new frame already shows the freshly swapped value.
  assign shadow_val_nxt = swap ? pend_val : shadow_val;
  assign shadow_dp_nxt  = swap ? pend_dp  : shadow_dp;

  // lzN: digit N and every digit to its left are zero.
  assign lz0 = (shadow_val_nxt[15:12] == 4'd0);
  assign lz1 = lz0 && (shadow_val_nxt[11:8] == 4'd0);
  assign lz2 = lz1 && (shadow_val_nxt[7:4]  == 4'd0);

  always_comb begin
    nib_nxt   = 4'd0;
    dp_nxt    = 1'b0;
    blank_nxt = !Enable;
    case (sel_nxt)
      2'd0: begin
        nib_nxt   = shadow_val_nxt[15:12];
        dp_nxt    = shadow_dp_nxt[3];
        blank_nxt = !Enable || (BlankLeadZero && lz0);
      end
      2'd1: begin
        nib_nxt   = shadow_val_nxt[11:8];
        dp_nxt    = shadow_dp_nxt[2];
        blank_nxt = !Enable || (BlankLeadZero && lz1);
      end
      2'd2: begin
        nib_nxt   = shadow_val_nxt[7:4];
        dp_nxt    = shadow_dp_nxt[1];
        blank_nxt = !Enable || (BlankLeadZero && lz2);
      end
      default: begin
        // Rightmost digit is never zero-blanked so a value of 0 shows "0".
        nib_nxt   = shadow_val_nxt[3:0];
        dp_nxt    = shadow_dp_nxt[0];
        blank_nxt = !Enable;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler  <= '0;
      DigitSel   <= 2'd0;
      pend_val   <= 16'd0;
      pend_dp    <= 4'd0;
      shadow_val <= 16'd0;
      shadow_dp  <= 4'd0;
      UpdPending <= 1'b0;
      Nibble     <= 4'd0;
      Dp         <= 1'b0;
      DigitBlank <= 1'b0;
      FrameTick  <= 1'b0;
    end else begin
      if (UpdValid) begin
        pend_val <= UpdData;
        pend_dp  <= UpdDp;
      end
      // A strobe on the swap edge keeps the flag set for its own data.
      UpdPending <= UpdValid || (UpdPending && !wrap);
      FrameTick  <= wrap;
      if (advance) begin
        prescaler  <= '0;
        DigitSel   <= sel_nxt;
        shadow_val <= shadow_val_nxt;
        shadow_dp  <= shadow_dp_nxt;
        Nibble     <= nib_nxt;
        Dp         <= dp_nxt;
        DigitBlank <= blank_nxt;
      end else begin
        prescaler <= prescaler + PRE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller

module tb_seg_scan_controller;

  logic        clk;
  logic        reset_n;
  logic        UpdValid;
  logic [15:0] UpdData;
  logic [3:0]  UpdDp;
  logic        BlankLeadZero;
  logic        Enable;
  logic [1:0]  DigitSel;
  logic [3:0]  Nibble;
  logic        Dp;
  logic        DigitBlank;
  logic        FrameTick;
  logic        UpdPending;

  seg_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .UpdValid      (UpdValid),
    .UpdData       (UpdData),
    .UpdDp         (UpdDp),
    .BlankLeadZero (BlankLeadZero),
    .Enable        (Enable),
    .DigitSel      (DigitSel),
    .Nibble        (Nibble),
    .Dp            (Dp),
    .DigitBlank    (DigitBlank),
    .FrameTick     (FrameTick),
    .UpdPending    (UpdPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       pend;
  } exp_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        blz;
    logic        en;
    logic [3:0]  blank;   // bit 3 = digit 0
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {DigitSel, Nibble, Dp, DigitBlank, FrameTick, UpdPending};
  endfunction

  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp,
                            input logic [3:0] blank, input logic pend);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.sel   = 2'(d);
      e.nib   = val[15-4*d -: 4];
      e.dp    = dp[3-d];
      e.blank = blank[3-d];
      e.pend  = pend;
      sb.push_back(e);
    end
  endtask

  task automatic wait_digit_start(input logic [1:0] target);
    int n = 0;
    while (DigitSel == target && n < 40) begin @(negedge clk); n++; end
    while (DigitSel != target && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("wait_digit_timeout", 32'(DigitSel), 32'(target));
  endtask

  // Checks one full frame cycle-by-cycle against four queued digit records.
  task automatic check_frame(input string name);
    exp_t e;
    int   n = 0;
    while (!FrameTick && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk({name, "_tick_timeout"}, 32'(FrameTick), 32'd1);
    for (int d = 0; d < 4; d++) begin
      if (sb.size() == 0) begin
        chk({name, "_sb_empty"}, 32'd0, 32'd1);
        return;
      end
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s_d%0d_c%0d", name, d, c), 32'(outs()),
            32'({e.sel, e.nib, e.dp, e.blank, (d == 0 && c == 0), e.pend}));
        @(negedge clk);
      end
    end
  endtask

  task automatic strobe(input logic [15:0] val, input logic [3:0] dp);
    UpdValid = 1'b1;
    UpdData  = val;
    UpdDp    = dp;
    @(negedge clk);
    UpdValid = 1'b0;
  endtask

  initial begin
    int n;

    vecs[0] = '{16'h0042, 4'b0000, 1'b1, 1'b1, 4'b1100};
    vecs[1] = '{16'h0000, 4'b0000, 1'b1, 1'b1, 4'b1110};
    vecs[2] = '{16'h1234, 4'b0100, 1'b0, 1'b1, 4'b0000};
    vecs[3] = '{16'h0F00, 4'b0001, 1'b1, 1'b1, 4'b1000};
    vecs[4] = '{16'h0042, 4'b1010, 1'b0, 1'b1, 4'b0000};
    vecs[5] = '{16'h000A, 4'b0000, 1'b1, 1'b1, 4'b1110};
    vecs[6] = '{16'h1234, 4'b1111, 1'b1, 1'b0, 4'b1111};
    vecs[7] = '{16'h0100, 4'b0000, 1'b1, 1'b1, 4'b1000};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
    vecs[9] = '{16'hF00F, 4'b0110, 1'b1, 1'b1, 4'b0000};

    reset_n       = 1'b0;
    UpdValid      = 1'b0;
    UpdData       = 16'h0;
    UpdDp         = 4'h0;
    BlankLeadZero = 1'b0;
    Enable        = 1'b1;

    // Reset for two cycles, then release and watch the free-running scan.
    @(negedge clk);
    chk("reset_outs_1", 32'(outs()), 32'd0);
    @(negedge clk);
    chk("reset_outs_2", 32'(outs()), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("scan_k%0d", k), 32'(outs()),
          32'({2'((k / 4) % 4), 4'd0, 1'b0, 1'b0, (k == 16), 1'b0}));
      @(negedge clk);
    end
    chk("scan_k20_sel", 32'(DigitSel), 32'd1);

    // Update while digit 1 is showing: old value stays until the wrap.
    push_frame(16'h1234, 4'b0100, 4'b0000, 1'b0);
    strobe(16'h1234, 4'b0100);
    n = 0;
    while (!FrameTick && n < 40) begin
      chk("pre_swap_nibble", 32'(Nibble), 32'd0);
      chk("pre_swap_pending", 32'(UpdPending), 32'd1);
      @(negedge clk);
      n++;
    end
    check_frame("upd_1234");

    // Table-driven values, blanking and enable combinations.
    for (int i = 0; i < 10; i++) begin
      wait_digit_start(2'd1);
      BlankLeadZero = vecs[i].blz;
      Enable        = vecs[i].en;
      push_frame(vecs[i].val, vecs[i].dp, vecs[i].blank, 1'b0);
      strobe(vecs[i].val, vecs[i].dp);
      check_frame($sformatf("vec%0d", i));
    end

    // Second update landing exactly on the swap edge.
    BlankLeadZero = 1'b0;
    Enable        = 1'b1;
    wait_digit_start(2'd1);
    push_frame(16'hAAAA, 4'b1000, 4'b0000, 1'b1);
    push_frame(16'hBBBB, 4'b0001, 4'b0000, 1'b0);
    strobe(16'hAAAA, 4'b1000);
    wait_digit_start(2'd3);
    repeat (3) @(negedge clk);
    strobe(16'hBBBB, 4'b0001);
    check_frame("swap_aaaa");
    check_frame("swap_bbbb");

    // Enable low for a whole frame, then re-enable mid-digit.
    wait_digit_start(2'd1);
    Enable = 1'b0;
    push_frame(16'hBBBB, 4'b0001, 4'b1111, 1'b0);
    check_frame("enable_low");
    repeat (5) @(negedge clk);
    chk("reenable_sel", 32'(DigitSel), 32'd1);
    Enable = 1'b1;
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("reenable_hold_c%0d", c), 32'(DigitBlank), 32'd1);
      @(negedge clk);
    end
    chk("reenable_next_digit", 32'({DigitSel, DigitBlank}), 32'({2'd2, 1'b0}));

    // Reset mid-scan at digit 2, prescaler 1, with an update pending.
    wait_digit_start(2'd1);
    strobe(16'h5678, 4'b1111);
    wait_digit_start(2'd2);
    @(negedge clk);
    chk("midreset_pending_before", 32'(UpdPending), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midreset_hold_k%0d", k), 32'(outs()), 32'd0);
      @(negedge clk);
    end
    chk("midreset_adv_sel", 32'(DigitSel), 32'd1);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
    check_frame("midreset_shadow");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
